// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan decoder.
// Holds the active-low segment codes (bit 0 = A .. bit 6 = G) for digits 0-9 and blank,
// the pattern type and the acceptance state machine encoding.
package seven_seg_pkg;

  typedef logic [6:0] seg_pattern_t;

  localparam seg_pattern_t SEG_0     = 7'b1000000;
  localparam seg_pattern_t SEG_1     = 7'b1111001;
  localparam seg_pattern_t SEG_2     = 7'b0100100;
  localparam seg_pattern_t SEG_3     = 7'b0110000;
  localparam seg_pattern_t SEG_4     = 7'b0011001;
  localparam seg_pattern_t SEG_5     = 7'b0010010;
  localparam seg_pattern_t SEG_6     = 7'b0000010;
  localparam seg_pattern_t SEG_7     = 7'b1111000;
  localparam seg_pattern_t SEG_8     = 7'b0000000;
  localparam seg_pattern_t SEG_9     = 7'b0011000;
  localparam seg_pattern_t SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HELD
  } state_t;

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Display bus monitored by the scan decoder plus the recovered-digit results.
// master: drives the display bus (seg_n, an_n) and observes the results.
// slave : the decoder; reads the display bus and drives digits/dp/valid/err_*/frame_done.
interface seven_seg_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   valid;
  logic                    err_pulse;
  logic [2:0]              err_digit;
  logic                    frame_done;

  modport master (
    output seg_n, an_n,
    input  digits, dp, valid, err_pulse, err_digit, frame_done
  );

  modport slave (
    input  seg_n, an_n,
    output digits, dp, valid, err_pulse, err_digit, frame_done
  );
endinterface

// File: rtl/seven_seg_pattern_decode.sv
// Combinational inverse of the BCD-to-seven-segment encoder.
// Ports: i_pattern (segments G..A, active-low) -> o_value (0-9, 4'hF otherwise),
//        o_legal (pattern is a digit 0-9), o_blank (all segments off).
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  seg_pattern_t i_pattern,
  output logic [3:0]   o_value,
  output logic         o_legal,
  output logic         o_blank
);

  always_comb begin
    o_value = 4'hF;
    o_legal = 1'b1;
    o_blank = 1'b0;
    case (i_pattern)
      SEG_0:     o_value = 4'd0;
      SEG_1:     o_value = 4'd1;
      SEG_2:     o_value = 4'd2;
      SEG_3:     o_value = 4'd3;
      SEG_4:     o_value = 4'd4;
      SEG_5:     o_value = 4'd5;
      SEG_6:     o_value = 4'd6;
      SEG_7:     o_value = 4'd7;
      SEG_8:     o_value = 4'd8;
      SEG_9:     o_value = 4'd9;
      SEG_BLANK: begin
        o_legal = 1'b0;
        o_blank = 1'b1;
      end
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers the digits shown on a time-multiplexed active-low seven-segment display.
// A {an_n, seg_n} sample must be stable for STABLE_CYCLES+1 edges with exactly one anode
// low before it is committed to that digit's storage.
// Ports: clk, reset (async, active-high); bus (slave): seg_n/an_n in,
//        digits/dp/valid/err_pulse/err_digit/frame_done out.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input logic                     clk,
  input logic                     reset,
  seven_seg_scan_decoder_if.slave bus
);

  localparam int unsigned SAMPLE_W = NUM_DIGITS + 8;
  localparam int unsigned CNT_W    = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // True when exactly one anode enable is low.
  function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
    int unsigned zeros;
    zeros = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [SAMPLE_W-1:0]     w_sample, r_sample;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [NUM_DIGITS-1:0]   w_held_an, w_sel;
  logic [7:0]              w_held_seg;
  logic                    w_match, w_new_onehot, w_commit, w_illegal_commit;
  logic [2:0]              w_idx;
  logic [3:0]              w_value;
  logic                    w_legal, w_blank;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp, r_valid, r_seen, w_seen_nxt;
  logic                    w_all_seen;
  logic                    r_err_pulse, r_frame_done;
  logic [2:0]              r_err_digit;

  assign w_sample     = {bus.an_n, bus.seg_n};
  assign w_match      = (w_sample == r_sample);
  assign w_new_onehot = one_low(bus.an_n);
  assign w_held_an    = r_sample[SAMPLE_W-1:8];
  assign w_held_seg   = r_sample[7:0];
  assign w_sel        = ~w_held_an;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel[i]) w_idx = 3'(i);
    end
  end

  // On commit the held sample equals the input, so decoding the held copy is exact.
  seven_seg_pattern_decode u_decode (
    .i_pattern (w_held_seg[6:0]),
    .o_value   (w_value),
    .o_legal   (w_legal),
    .o_blank   (w_blank)
  );

  // Stability counter and acceptance FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    if (!w_match) begin
      w_cnt_nxt   = '0;
      w_state_nxt = w_new_onehot ? COUNT : IDLE;
    end else begin
      if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
      // COUNT is only ever entered with a one-hot-low anode field held.
      if (r_state == COUNT && r_cnt == CNT_MAX) begin
        w_commit    = 1'b1;
        w_state_nxt = HELD;
      end
    end
  end

  assign w_illegal_commit = w_commit & ~w_legal & ~w_blank;

  // A commit landing on the clearing edge seeds the fresh mask.
  assign w_all_seen = &r_seen;
  assign w_seen_nxt = (w_all_seen ? '0 : r_seen) | (w_commit ? w_sel : '0);

  // The reset sample has no anode low, so any one-hot input is seen as a change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample <= '1;
      r_cnt    <= '0;
      r_state  <= IDLE;
    end else begin
      r_sample <= w_sample;
      r_cnt    <= w_cnt_nxt;
      r_state  <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits <= '1;
      r_dp     <= '0;
      r_valid  <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_sel[i]) begin
          if (w_legal) begin
            r_digits[4*i +: 4] <= w_value;
            r_dp[i]            <= ~w_held_seg[7];
            r_valid[i]         <= 1'b1;
          end else if (w_blank) begin
            r_digits[4*i +: 4] <= 4'hF;
            r_dp[i]            <= ~w_held_seg[7];
            r_valid[i]         <= 1'b0;
          end else begin
            r_valid[i]         <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_pulse  <= 1'b0;
      r_err_digit  <= '0;
      r_seen       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_err_pulse  <= w_illegal_commit;
      if (w_illegal_commit) r_err_digit <= w_idx;
      r_seen       <= w_seen_nxt;
      r_frame_done <= w_all_seen;
    end
  end

  assign bus.digits     = r_digits;
  assign bus.dp         = r_dp;
  assign bus.valid      = r_valid;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_digit  = r_err_digit;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder: a scoreboard of predicted commits is
// filled when each display pattern is driven and drained at the predicted commit edge.
module tb_seven_seg_scan_decoder;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();
  seven_seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus2 ();

  seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    int         digit;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  dp;
    logic        err;
    logic [2:0]  err_digit;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;
  int err_count = 0;
  int err2_count = 0;

  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_dp, m_seen;
  logic [2:0]  m_err_digit;
  logic [11:0] m_prev;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_count++;
    if (bus.err_pulse === 1'b1) err_count++;
    if (bus2.err_pulse === 1'b1) err2_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0-9 for a digit, 15 for blank, -1 for an illegal pattern.
  function automatic int decode_model(input logic [6:0] p);
    case (p)
      7'b1000000: return 0;
      7'b1111001: return 1;
      7'b0100100: return 2;
      7'b0110000: return 3;
      7'b0011001: return 4;
      7'b0010010: return 5;
      7'b0000010: return 6;
      7'b1111000: return 7;
      7'b0000000: return 8;
      7'b0011000: return 9;
      7'b1111111: return 15;
      default:    return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_digits    = 16'hFFFF;
    m_valid     = '0;
    m_dp        = '0;
    m_seen      = '0;
    m_err_digit = '0;
    m_prev      = 12'hFFF;
    sb.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "/digits"}, bus.digits, 16'hFFFF);
    check_eq({tag, "/valid"}, bus.valid, 0);
    check_eq({tag, "/dp"}, bus.dp, 0);
    check_eq({tag, "/err_pulse"}, bus.err_pulse, 0);
    check_eq({tag, "/err_digit"}, bus.err_digit, 0);
    check_eq({tag, "/frame_done"}, bus.frame_done, 0);
  endtask

  // Called at posedge+1; asserts reset asynchronously and checks it takes effect at once.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drive one pattern for a number of edges, predicting and checking every cycle.
  task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int cycles,
                       input string tag);
    int   idx;
    int   v;
    logic commit_due;
    logic fd_exp;
    exp_t e;
    bus.an_n  = an;
    bus.seg_n = seg;
    idx = -1;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) idx = (idx == -1) ? i : -2;
    end
    commit_due = (idx >= 0) && (cycles >= SC + 1) && ({an, seg} != m_prev);
    m_prev = {an, seg};
    if (commit_due) begin
      v = decode_model(seg[6:0]);
      e.digit = idx;
      e.err   = 1'b0;
      if (v >= 0 && v <= 9) begin
        m_digits[4*idx +: 4] = v[3:0];
        m_dp[idx]            = ~seg[7];
        m_valid[idx]         = 1'b1;
      end else if (v == 15) begin
        m_digits[4*idx +: 4] = 4'hF;
        m_dp[idx]            = ~seg[7];
        m_valid[idx]         = 1'b0;
      end else begin
        m_valid[idx] = 1'b0;
        m_err_digit  = 3'(idx);
        e.err        = 1'b1;
      end
      e.digits    = m_digits;
      e.valid     = m_valid;
      e.dp        = m_dp;
      e.err_digit = m_err_digit;
      sb.push_back(e);
    end
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk);
      fd_exp = (m_seen == 4'hF);
      if (fd_exp) m_seen = '0;
      if (commit_due && k == SC + 1) m_seen[idx] = 1'b1;
      #1;
      check_eq({tag, "/frame_done"}, bus.frame_done, fd_exp);
      if (commit_due && k == SC + 1) begin
        if (sb.size() == 0) begin
          check_eq({tag, "/scoreboard_empty"}, 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq({tag, "/digits"}, bus.digits, e.digits);
          check_eq({tag, "/valid"}, bus.valid, e.valid);
          check_eq({tag, "/dp"}, bus.dp, e.dp);
          check_eq({tag, "/err_pulse"}, bus.err_pulse, e.err);
          check_eq({tag, "/err_digit"}, bus.err_digit, e.err_digit);
        end
      end else begin
        check_eq({tag, "/err_quiet"}, bus.err_pulse, 0);
      end
    end
  endtask

  task automatic drive2(input logic [3:0] an, input logic [7:0] seg, input int cycles);
    bus2.an_n  = an;
    bus2.seg_n = seg;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int fd_before;
    int err_before;
    bus.an_n   = '1;
    bus.seg_n  = '1;
    bus2.an_n  = '1;
    bus2.seg_n = '1;
    model_reset();
    #2;
    do_reset("reset");

    // 8 edges is one short of acceptance.
    drive(4'b1110, 8'b10110000, 8, "short");
    check_eq("short/valid", bus.valid, 0);
    drive(4'b1111, 8'hFF, 1, "gap");
    drive(4'b1110, 8'b10110000, 9, "three");
    check_eq("three/digit0", bus.digits[3:0], 4'd3);
    check_eq("three/valid0", bus.valid[0], 1);
    check_eq("three/dp0", bus.dp[0], 0);

    fd_before = fd_count;
    drive(4'b1110, 8'b11111001, 12, "scan0");
    drive(4'b1101, 8'b10100100, 12, "scan1");
    drive(4'b1011, 8'b10011001, 12, "scan2");
    drive(4'b0111, 8'b10000000, 12, "scan3");
    check_eq("scan/digits", bus.digits, 16'h8421);
    check_eq("scan/valid", bus.valid, 4'hF);
    check_eq("scan/frame_pulses", fd_count - fd_before, 1);

    err_before = err_count;
    drive(4'b1101, 8'b11011000, 20, "illegal");
    check_eq("illegal/pulses", err_count - err_before, 1);
    check_eq("illegal/err_digit", bus.err_digit, 1);
    check_eq("illegal/valid1", bus.valid[1], 0);
    check_eq("illegal/digit1", bus.digits[7:4], 4'd2);

    err_before = err_count;
    drive(4'b1100, 8'b11000000, 30, "two_anodes");
    check_eq("two_anodes/digits", bus.digits, 16'h8421);
    check_eq("two_anodes/pulses", err_count - err_before, 0);

    drive(4'b1011, 8'b00011000, 9, "nine_dp");
    check_eq("nine_dp/digit2", bus.digits[11:8], 4'd9);
    check_eq("nine_dp/dp2", bus.dp[2], 1);

    drive(4'b1110, 8'b11111001, 4, "partial");
    do_reset("midreset");
    drive(4'b1110, 8'b10110000, 9, "after_reset");

    // Short-window instance: a 2-edge glitch between two 3-edge patterns.
    drive2(4'b1110, 8'b11111001, 3);
    drive2(4'b1011, 8'b10000000, 2);
    drive2(4'b1101, 8'b10010010, 3);
    drive2(4'b1111, 8'hFF, 2);
    check_eq("glitch/digits", bus2.digits, 16'hFF51);
    check_eq("glitch/valid", bus2.valid, 4'b0011);
    check_eq("glitch/err", err2_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

- Monitors a time-multiplexed, active-low seven-segment display bus (shared segment lines plus per-digit anode enables) and recovers the digit value shown at each position.
- It is the receiving end of our BCD-to-seven-segment encoding: segment bit 0 = A through bit 6 = G, bit 7 = DP, all active-low.
- It drives on-chip display self-check, and it feeds scoreboards in the display-path testbenches.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digit positions (1–8).
- STABLE_CYCLES, 8: consecutive identical samples required before a pattern is accepted (≥2).

Ports:
- clk  input  1: single clock; all state on its rising edge.
- reset  input  1: asynchronous, active-high reset.
- seg_n  input  8: segment bus, active-low; [6:0] = G..A, [7] = DP.
- an_n  input  NUM_DIGITS: digit enables, active-low; exactly one low selects that digit.
- digits  output  4*NUM_DIGITS: recovered values; digit i at [4i+3:4i].
- dp  output  NUM_DIGITS: decimal point state per digit, 1 = lit.
- valid  output  NUM_DIGITS: digit i holds a legally decoded 0–9 value.
- err_pulse  output  1: one-cycle pulse when an illegal pattern is accepted.
- err_digit  output  3: index of the last digit that raised err_pulse.
- frame_done  output  1: one-cycle pulse when every digit has been accepted since the previous pulse.

## Operation
- The legal codes for seg_n[6:0] (G..A) are:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0011000
- Blank = 1111111. Every other pattern is illegal.
- Sample register: {an_n, seg_n} is captured each edge. A stability counter compares the new sample to the held one.
  - Mismatch: load the new sample, counter = 0, state COUNT.
  - Match: the counter increments, saturating at STABLE_CYCLES-1.
- The state machine has three states:
  - IDLE: the held sample has no single low anode (zero or ≥2 bits low). No commit. Leave IDLE on any sample change.
  - COUNT: a single anode is low and the counter is below STABLE_CYCLES-1. On a matching sample with counter == STABLE_CYCLES-1, commit and go to HELD.
  - HELD: the pattern is already committed and is never re-committed. Any sample change goes to COUNT, or to IDLE if the new anode field is not one-hot-low.
- Commit for selected digit i:
  - Legal 0–9: digits[i] = value, dp[i] = ~seg_n[7], valid[i] = 1.
  - Blank: digits[i] = 4'hF, dp[i] = ~seg_n[7], valid[i] = 0. Blank is not an error.
  - Illegal: digits[i] unchanged, valid[i] = 0, err_pulse = 1, err_digit = i.
- Frame mask: seen[i] is set on any commit to digit i.
  - When seen becomes all-ones, frame_done pulses the next cycle and seen clears.
  - A commit arriving in the same cycle as the clear is kept, with its bit set in the fresh mask.
- DP is ignored for legality.

## Timing
- Reset values:
  - digits all 4'hF; dp, valid, seen all 0.
  - err_pulse 0, err_digit 0, frame_done 0.
  - State IDLE, counter 0.
- Reset asserted mid-count or mid-frame clears everything immediately. Counting restarts from the first edge after deassertion.
- Acceptance: a {an_n, seg_n} value must be present for STABLE_CYCLES+1 consecutive rising edges. It commits on the last of those edges, and outputs are visible right after that edge.
- Anything shorter never commits, including ghosting during anode transitions.
- err_pulse is registered and high for exactly the cycle following the committing edge. It is never high in consecutive cycles, because HELD blocks re-commit.
- frame_done is high exactly one cycle after the edge that completed the mask.
- err_pulse and frame_done may assert together.
- The counter saturates, so an indefinitely held pattern never wraps or re-triggers.

## Structure
- Shared package seven_seg_pkg holds:
  - the ten legal segment code localparams plus SEG_BLANK
  - the typedef seg_pattern_t (logic [6:0])
  - the state enum {IDLE, COUNT, HELD}
- Sub-module seven_seg_pattern_decode is the combinational inverse lookup: seg_pattern_t in → 4-bit value, legal flag, blank flag.
- The top level holds the sample register, counter, FSM, per-digit storage and frame mask.

## Test plan
All scenarios use NUM_DIGITS = 4 and STABLE_CYCLES = 8 unless stated otherwise.
- Reset, then an_n = 1110, seg_n = 8'b10110000 held for 9 edges:
  - digits[3:0] = 3, valid[0] = 1, dp[0] = 0.
  - Holding for 8 edges only leaves valid = 0.
- Scan digits 0–3 with codes 1, 2, 4, 8, each held 12 cycles:
  - digits = 16'h8421, valid = 4'hF.
  - frame_done pulses once, one cycle after the digit-3 commit.
- an_n = 1101, seg_n = 8'b11011000 (illegal) held 20 cycles:
  - err_pulse is high exactly 1 cycle, err_digit = 1, valid[1] = 0, digits[1] unchanged.
- an_n = 1100 (two digits low) with a legal code held 30 cycles: no commit, no err_pulse.
- Commit 9 with DP lit (seg_n = 8'b00011000) on digit 2, then assert reset mid-count of the next pattern:
  - All outputs return to reset values, digits = 16'hFFFF.
- STABLE_CYCLES = 2; a glitch pattern lasting 2 edges between two valid 3-edge patterns:
  - Only the two valid patterns commit.
